// File: rtl/os_ctrl_pkg.sv
// Shared definitions for the output-stationary array controller: state encoding,
// feed-length helper and the select polarities the array decodes.
package os_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // stat: 1 keeps the PEs accumulating; op2: 1 forces a zero operand; out: 1 drains.
    localparam logic STAT_ACCUM  = 1'b1;
    localparam logic STAT_HOLD   = 1'b0;
    localparam logic OP2_ZERO    = 1'b1;
    localparam logic OP2_OPERAND = 1'b0;
    localparam logic OUT_DRAIN   = 1'b1;
    localparam logic OUT_PASS    = 1'b0;

    // Cycles needed for the last skewed operand pair to reach the far corner PE.
    function automatic int f_len(input int klat, input int rows, input int cols);
        return klat + rows + cols - 2;
    endfunction

endpackage

// File: rtl/os_skew_enable_gen.sv
// Skewed operand-valid window: lane i is live for feed cycles t in [i, i+klat).
module os_skew_enable_gen #(
    parameter int N     = 32,
    parameter int CNT_W = 9,
    parameter int KL_W  = 9
) (
    input  logic [CNT_W-1:0] t,
    input  logic [KL_W-1:0]  klat,
    output logic [N-1:0]     en
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign en[i] = (32'(t) >= 32'(i)) && (32'(t) < 32'(i) + 32'(klat));
    end

endmodule

// File: rtl/os_systolic_ctrl.sv
// Tile sequencer for the output-stationary MAC array: clear, skewed feed, drain, done.
// Optional OS_CTRL_PERF_EN adds tile and busy-cycle performance counters.
module os_systolic_ctrl
    import os_ctrl_pkg::*;
#(
    parameter int ROWS  = 32,
    parameter int COLS  = 32,
    parameter int K_MAX = 256,
    parameter int CNT_W = $clog2(K_MAX + ROWS + COLS),
    parameter int KL_W  = $clog2(K_MAX + 1),
    localparam int DRW  = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KL_W-1:0]  k_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             ctl_stat_bit_out,
    output logic             ctl_fsm_op2_select_out,
    output logic             ctl_fsm_out_select_out,
    output logic [ROWS-1:0]  row_feed_en,
    output logic [COLS-1:0]  col_feed_en,
    output logic [CNT_W-1:0] feed_idx,
    output logic             drain_valid,
`ifdef OS_CTRL_PERF_EN
    output logic [31:0]      perf_tiles,
    output logic [31:0]      perf_busy_cycles,
`endif
    output logic [DRW-1:0]   drain_row
);

    state_t           state_q, state_d;
    logic [KL_W-1:0]  klat_q, klat_d;
    logic [CNT_W-1:0] t_q, t_d, t_last;
    logic [DRW-1:0]   dcnt_q, dcnt_d;
    logic [ROWS-1:0]  row_en;
    logic [COLS-1:0]  col_en;

    assign t_last = CNT_W'(f_len(int'(klat_q), ROWS, COLS) - 1);

    always_comb begin
        state_d = state_q;
        klat_d  = klat_q;
        t_d     = t_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_CLEAR;
                klat_d  = (k_len > KL_W'(K_MAX)) ? KL_W'(K_MAX) : k_len;
            end
            ST_CLEAR: begin
                t_d     = '0;
                state_d = (klat_q == '0) ? ST_DONE : ST_FEED;
            end
            ST_FEED: if (t_q == t_last) begin
                state_d = ST_DRAIN;
                dcnt_d  = DRW'(ROWS - 1);
            end else begin
                t_d = t_q + 1'b1;
            end
            ST_DRAIN: if (dcnt_q == '0) state_d = ST_DONE;
                      else dcnt_d = dcnt_q - 1'b1;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Enables are decoded from next-state values so the registered outputs line up with the state.
    os_skew_enable_gen #(.N(ROWS), .CNT_W(CNT_W), .KL_W(KL_W)) u_row_skew (
        .t(t_d), .klat(klat_d), .en(row_en));
    os_skew_enable_gen #(.N(COLS), .CNT_W(CNT_W), .KL_W(KL_W)) u_col_skew (
        .t(t_d), .klat(klat_d), .en(col_en));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            klat_q  <= '0;
            t_q     <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            klat_q  <= klat_d;
            t_q     <= t_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy                   <= 1'b0;
            done                   <= 1'b0;
            ctl_stat_bit_out       <= 1'b0;
            ctl_fsm_op2_select_out <= 1'b0;
            ctl_fsm_out_select_out <= 1'b0;
            row_feed_en            <= '0;
            col_feed_en            <= '0;
            feed_idx               <= '0;
            drain_valid            <= 1'b0;
            drain_row              <= '0;
        end else begin
            busy                   <= (state_d != ST_IDLE);
            done                   <= (state_d == ST_DONE);
            ctl_stat_bit_out       <= (state_d == ST_CLEAR || state_d == ST_FEED) ? STAT_ACCUM : STAT_HOLD;
            ctl_fsm_op2_select_out <= (state_d == ST_CLEAR) ? OP2_ZERO : OP2_OPERAND;
            ctl_fsm_out_select_out <= (state_d == ST_DRAIN) ? OUT_DRAIN : OUT_PASS;
            row_feed_en            <= (state_d == ST_FEED) ? row_en : '0;
            col_feed_en            <= (state_d == ST_FEED) ? col_en : '0;
            feed_idx               <= (state_d == ST_FEED) ? t_d : '0;
            drain_valid            <= (state_d == ST_DRAIN);
            drain_row              <= (state_d == ST_DRAIN) ? dcnt_d : '0;
        end
    end

`ifdef OS_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_tiles       <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (done) perf_tiles       <= perf_tiles + 32'd1;
            if (busy) perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_os_systolic_ctrl.sv
// Directed bench for os_systolic_ctrl (4x4 array, K_MAX=8) with a per-cycle expected-trace queue.
module tb_os_systolic_ctrl;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int K_MAX = 8;
    localparam int CNT_W = $clog2(K_MAX + ROWS + COLS);
    localparam int KL_W  = $clog2(K_MAX + 1);
    localparam int DRW   = $clog2(ROWS);
    localparam int OW    = 5 + ROWS + COLS + CNT_W + 1 + DRW;

    typedef logic [OW-1:0] vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [KL_W-1:0]  k_len;
    logic             abort;
    logic             busy, done, stat, op2, outs, drain_valid;
    logic [ROWS-1:0]  row_feed_en;
    logic [COLS-1:0]  col_feed_en;
    logic [CNT_W-1:0] feed_idx;
    logic [DRW-1:0]   drain_row;
`ifdef OS_CTRL_PERF_EN
    logic [31:0]      perf_tiles, perf_busy_cycles;
`endif

    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    vec_t q[$];

    os_systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
        .busy(busy), .done(done),
        .ctl_stat_bit_out(stat), .ctl_fsm_op2_select_out(op2), .ctl_fsm_out_select_out(outs),
        .row_feed_en(row_feed_en), .col_feed_en(col_feed_en), .feed_idx(feed_idx),
        .drain_valid(drain_valid),
`ifdef OS_CTRL_PERF_EN
        .perf_tiles(perf_tiles), .perf_busy_cycles(perf_busy_cycles),
`endif
        .drain_row(drain_row));

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic b, input logic d, input logic s, input logic o2,
                                input logic os, input logic [ROWS-1:0] re, input logic [COLS-1:0] ce,
                                input logic [CNT_W-1:0] idx, input logic dv, input logic [DRW-1:0] dr);
        return {b, d, s, o2, os, re, ce, idx, dv, dr};
    endfunction

    // Expected outputs during cycle c of a tile whose start was sampled at edge 0.
    function automatic vec_t exp_at(input int klat, input int c);
        int f;
        int t;
        logic [ROWS-1:0] re;
        logic [COLS-1:0] ce;
        f = klat + ROWS + COLS - 2;
        re = '0;
        ce = '0;
        if (c == 1) return mk(1, 0, 1, 1, 0, '0, '0, '0, 0, '0);
        if (klat == 0) return (c == 2) ? mk(1, 1, 0, 0, 0, '0, '0, '0, 0, '0) : '0;
        if (c >= 2 && c <= f + 1) begin
            t = c - 2;
            for (int r = 0; r < ROWS; r++) re[r] = (t >= r) && (t < r + klat);
            for (int k = 0; k < COLS; k++) ce[k] = (t >= k) && (t < k + klat);
            return mk(1, 0, 1, 0, 0, re, ce, CNT_W'(t), 0, '0);
        end
        if (c >= f + 2 && c <= f + ROWS + 1)
            return mk(1, 0, 0, 0, 1, '0, '0, '0, 1, DRW'(ROWS - 1 - (c - f - 2)));
        if (c == f + ROWS + 2) return mk(1, 1, 0, 0, 0, '0, '0, '0, 0, '0);
        return '0;
    endfunction

    // Pushes cycles 1..last_c; last_c<0 means the full tile plus one idle cycle.
    task automatic push_tile(input int klen, input int last_c);
        int klat;
        int n;
        klat = (klen > K_MAX) ? K_MAX : klen;
        n = (last_c < 0) ? ((klat == 0) ? 3 : klat + ROWS + COLS - 2 + ROWS + 3) : last_c;
        for (int c = 1; c <= n; c++) q.push_back(exp_at(klat, c));
    endtask

    task automatic check(input vec_t e, input string tag);
        vec_t obs;
        obs = {busy, done, stat, op2, outs, row_feed_en, col_feed_en, feed_idx, drain_valid, drain_row};
        nvec++;
        assert (obs === e) else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks the queue one cycle at a time; start drops after cycle hold_until, abort pulses after cycle abort_at.
    task automatic run(input string tag, input int hold_until, input int abort_at);
        int c;
        c = 0;
        while (q.size() > 0) begin
            tick();
            c++;
            cyc = c;
            check(q.pop_front(), tag);
            if (c >= hold_until) start = 1'b0;
            abort = (c == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        #3;
        check('0, "reset");
        #9 rst = 1'b1;
        tick();
        check('0, "idle_after_reset");

        k_len = KL_W'(3); start = 1'b1; push_tile(3, -1); run("tile_k3", 0, 0);
        k_len = KL_W'(0); start = 1'b1; push_tile(0, -1); run("tile_k0", 0, 0);
        k_len = KL_W'(K_MAX + 5); start = 1'b1; push_tile(K_MAX + 5, -1); run("tile_ksat", 0, 0);

        // start held for the whole tile is ignored until IDLE; dropped on the done cycle
        k_len = KL_W'(1); start = 1'b1; push_tile(1, -1); run("start_held", 13, 0);

        // abort at FEED t=5 (cycle 7) with start still held
        k_len = KL_W'(3); start = 1'b1; push_tile(3, 7); q.push_back('0); run("abort_feed", 99, 7);

        // abort beats start in IDLE
        k_len = KL_W'(2); start = 1'b1; abort = 1'b1; q.push_back('0); q.push_back('0);
        run("abort_vs_start", 0, 0);

        k_len = KL_W'(2); start = 1'b1; push_tile(2, -1); run("after_abort", 0, 0);

        // async reset in the second DRAIN cycle
        k_len = KL_W'(3); start = 1'b1; push_tile(3, 12); run("pre_reset", 0, 0);
        rst = 1'b0;
        #1;
        cyc = 12;
        check('0, "async_reset");
        #2 rst = 1'b1;

        k_len = KL_W'(1); start = 1'b1; push_tile(1, -1); run("post_reset_k1", 0, 0);

`ifdef OS_CTRL_PERF_EN
        nvec++;
        assert (perf_tiles === 32'd1 && perf_busy_cycles === 32'd13) else begin
            nerr++;
            $error("FAIL perf observed=%0d/%0d expected=1/13", perf_tiles, perf_busy_cycles);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
